// File: rtl/multi_cycle_alu_if.sv
// Operand/handshake bundle between an issuing controller and multi_cycle_alu.
interface multi_cycle_alu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       ALUOp;
   logic [WIDTH-1:0] readData1;
   logic [WIDTH-1:0] readData2;
   logic [WIDTH-1:0] immediate;
   logic             ALUSrcB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] resultHi;
   logic             zero;
   logic             overflow;
   logic             divByZero;

   modport master (
      output start, ALUOp, readData1, readData2, immediate, ALUSrcB,
      input  busy, done, result, resultHi, zero, overflow, divByZero
   );

   modport slave (
      input  start, ALUOp, readData1, readData2, immediate, ALUSrcB,
      output busy, done, result, resultHi, zero, overflow, divByZero
   );
endinterface

// File: rtl/multi_cycle_alu.sv
// Single-cycle ALU with optional iterative MULU/DIVU (one bit per cycle).
// Define ALU_MULDIV_EN to build the multiply/divide engine; otherwise 1100/1101 are reserved.
module multi_cycle_alu #(
   parameter int WIDTH = 32
) (
   input logic             CLK,
   input logic             Reset,
   multi_cycle_alu_if.slave bus
);
   localparam int SH_W = $clog2(WIDTH);

   typedef enum logic {IDLE, ITER} state_t;
   state_t state_q, state_d;

   logic                    accept, finish, is_iter, last_step;
   logic        [WIDTH-1:0] a_in, b_in;
   logic signed [WIDTH-1:0] a_s, b_s, add_ab, sub_ab, sub_ba;
   logic        [WIDTH-1:0] sc_lo, sc_hi, fin_lo, fin_hi;
   logic                    sc_ovf, sc_dbz;
   logic        [WIDTH-1:0] result_q, result_hi_q;
   logic                    zero_q, ovf_q, dbz_q, done_q;

   assign a_in   = bus.readData1;
   assign b_in   = bus.ALUSrcB ? bus.immediate : bus.readData2;
   assign a_s    = a_in;
   assign b_s    = b_in;
   assign add_ab = a_s + b_s;
   assign sub_ab = a_s - b_s;
   assign sub_ba = b_s - a_s;

   always_comb begin
      sc_lo  = '0;
      sc_hi  = '0;
      sc_ovf = 1'b0;
      sc_dbz = 1'b0;
      case (bus.ALUOp)
         4'b0000: begin
            sc_lo  = add_ab;
            sc_ovf = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (add_ab[WIDTH-1] != a_s[WIDTH-1]);
         end
         4'b0001: begin
            sc_lo  = sub_ab;
            sc_ovf = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (sub_ab[WIDTH-1] != a_s[WIDTH-1]);
         end
         4'b0010: begin
            sc_lo  = sub_ba;
            sc_ovf = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (sub_ba[WIDTH-1] != b_s[WIDTH-1]);
         end
         4'b0011: sc_lo = a_in | b_in;
         4'b0100: sc_lo = a_in & b_in;
         4'b0101: sc_lo = ~a_in & b_in;
         4'b0110: sc_lo = a_in ^ b_in;
         4'b0111: sc_lo = a_in ~^ b_in;
         4'b1000: sc_lo = b_in << a_in[SH_W-1:0];
         4'b1001: sc_lo = b_in >> a_in[SH_W-1:0];
         4'b1010: sc_lo = b_s >>> a_in[SH_W-1:0];
         4'b1011: sc_lo = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
`ifdef ALU_MULDIV_EN
         // Divide by zero bypasses the iteration and finishes immediately.
         4'b1101: begin
            if (b_in == '0) begin
               sc_lo  = '1;
               sc_hi  = a_in;
               sc_dbz = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

`ifdef ALU_MULDIV_EN
   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0] cnt_q;
   logic             mul_q;
   logic [WIDTH-1:0] a_q, b_q, acc_hi_q, acc_lo_q, step_hi, step_lo;
   logic [WIDTH:0]   mul_sum, div_sh;
   logic [WIDTH+1:0] div_diff;

   assign is_iter   = (bus.ALUOp == 4'b1100) || ((bus.ALUOp == 4'b1101) && (b_in != '0));
   assign last_step = (cnt_q == CNT_W'(WIDTH-1));

   // acc_hi/acc_lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
      div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff = {1'b0, div_sh} - {2'b00, b_q};
      if (mul_q) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end else if (div_diff[WIDTH+1]) begin
         step_hi = div_sh[WIDTH-1:0];
         step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end else begin
         step_hi = div_diff[WIDTH-1:0];
         step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end
   end

   assign fin_hi   = step_hi;
   assign fin_lo   = step_lo;
   assign bus.busy = (state_q == ITER);

   always_ff @(posedge CLK) begin
      if (!Reset)                cnt_q <= '0;
      else if (accept)           cnt_q <= '0;
      else if (state_q == ITER)  cnt_q <= cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         a_q      <= a_in;
         b_q      <= b_in;
         mul_q    <= (bus.ALUOp == 4'b1100);
         acc_hi_q <= '0;
         acc_lo_q <= (bus.ALUOp == 4'b1100) ? b_in : a_in;
      end else if (state_q == ITER) begin
         acc_hi_q <= step_hi;
         acc_lo_q <= step_lo;
      end
   end
`else
   assign is_iter   = 1'b0;
   assign last_step = 1'b1;
   assign fin_hi    = '0;
   assign fin_lo    = '0;
   assign bus.busy  = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!Reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept = 1'b1;
               if (is_iter) state_d = ITER;
            end
         end
         ITER: begin
            if (last_step) begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs only change on completion, so iteration state never leaks onto result.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
         dbz_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept && !is_iter) begin
            result_q    <= sc_lo;
            result_hi_q <= sc_hi;
            zero_q      <= (sc_lo == '0);
            ovf_q       <= sc_ovf;
            dbz_q       <= sc_dbz;
            done_q      <= 1'b1;
         end else if (finish) begin
            result_q    <= fin_lo;
            result_hi_q <= fin_hi;
            zero_q      <= (fin_lo == '0);
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b1;
         end
      end
   end

   assign bus.result    = result_q;
   assign bus.resultHi  = result_hi_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;
   assign bus.divByZero = dbz_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_multi_cycle_alu.sv
// Directed-vector bench for multi_cycle_alu (WIDTH=32); MULU/DIVU scenarios follow ALU_MULDIV_EN.
module tb_multi_cycle_alu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   multi_cycle_alu_if #(.WIDTH(32)) bus ();

   multi_cycle_alu #(.WIDTH(32)) dut (
      .CLK  (clk),
      .Reset(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
   } vec_t;

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic src, input logic [31:0] imm);
      bus.ALUOp     = op;
      bus.readData1 = a;
      bus.readData2 = b;
      bus.ALUSrcB   = src;
      bus.immediate = imm;
      bus.start     = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_cmp++; if (bus.busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.result !== 32'h0)   begin n_err++; $display("FAIL reset_result: got %h want 0", bus.result); end
      n_cmp++; if (bus.resultHi !== 32'h0) begin n_err++; $display("FAIL reset_resultHi: got %h want 0", bus.resultHi); end
      n_cmp++; if (bus.zero !== 1'b1)      begin n_err++; $display("FAIL reset_zero: got %b want 1", bus.zero); end
      n_cmp++; if (bus.overflow !== 1'b0)  begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
      n_cmp++; if (bus.divByZero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", bus.divByZero); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add_overflow();
      drive(4'b0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.done !== 1'b1)           begin n_err++; $display("FAIL add_done: got %b want 1", bus.done); end
      n_cmp++; if (bus.result !== 32'h8000_0000) begin n_err++; $display("FAIL add_result: got %h want 80000000", bus.result); end
      n_cmp++; if (bus.overflow !== 1'b1)       begin n_err++; $display("FAIL add_ovf: got %b want 1", bus.overflow); end
      tick();
      n_cmp++; if (bus.done !== 1'b0)           begin n_err++; $display("FAIL add_done_pulse: got %b want 0", bus.done); end
   endtask

   task automatic test_sub_immediate();
      drive(4'b0001, 32'd5, 32'd99, 1'b1, 32'd5);
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.result !== 32'h0)  begin n_err++; $display("FAIL subi_result: got %h want 0", bus.result); end
      n_cmp++; if (bus.zero !== 1'b1)     begin n_err++; $display("FAIL subi_zero: got %b want 1", bus.zero); end
      n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL subi_ovf: got %b want 0", bus.overflow); end
      tick();
   endtask

   task automatic test_single_cycle_ops();
      vec_t tbl [13] = '{
         '{4'b0011, 32'h0000_FF00, 32'h0F0F_0F0F, 32'h0F0F_FF0F, 1'b0},
         '{4'b0100, 32'h0000_FF00, 32'h0F0F_0F0F, 32'h0000_0F00, 1'b0},
         '{4'b0101, 32'h0000_FF00, 32'h0F0F_0F0F, 32'h0F0F_000F, 1'b0},
         '{4'b0110, 32'h0000_FF00, 32'h0F0F_0F0F, 32'h0F0F_F00F, 1'b0},
         '{4'b0111, 32'h0000_FF00, 32'h0F0F_0F0F, 32'hF0F0_0FF0, 1'b0},
         '{4'b0010, 32'h0000_FF00, 32'h0F0F_0F0F, 32'h0F0E_100F, 1'b0},
         '{4'b1000, 32'h0000_0004, 32'h8000_00F0, 32'h0000_0F00, 1'b0},
         '{4'b1001, 32'h0000_0004, 32'h8000_00F0, 32'h0800_000F, 1'b0},
         '{4'b1010, 32'h0000_0004, 32'h8000_00F0, 32'hF800_000F, 1'b0},
         '{4'b1000, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010, 1'b0},
         '{4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
         '{4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
         '{4'b1111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0}
      };
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 32'hDEAD_BEEF);
         tick();
         bus.start = 1'b0;
         n_cmp++; if (bus.done !== 1'b1)          begin n_err++; $display("FAIL op%0d_done: got %b want 1", i, bus.done); end
         n_cmp++; if (bus.result !== tbl[i].res)  begin n_err++; $display("FAIL op%0d_result: got %h want %h", i, bus.result, tbl[i].res); end
         n_cmp++; if (bus.resultHi !== 32'h0)     begin n_err++; $display("FAIL op%0d_resultHi: got %h want 0", i, bus.resultHi); end
         n_cmp++; if (bus.overflow !== tbl[i].ovf) begin n_err++; $display("FAIL op%0d_ovf: got %b want %b", i, bus.overflow, tbl[i].ovf); end
         n_cmp++; if (bus.zero !== (tbl[i].res == 32'h0)) begin n_err++; $display("FAIL op%0d_zero: got %b want %b", i, bus.zero, tbl[i].res == 32'h0); end
         tick();
      end
      // B-A overflow and SLT false case with a negative B
      drive(4'b0010, 32'h1, 32'h8000_0000, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.result !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL rsub_result: got %h want 7fffffff", bus.result); end
      n_cmp++; if (bus.overflow !== 1'b1)        begin n_err++; $display("FAIL rsub_ovf: got %b want 1", bus.overflow); end
      drive(4'b1011, 32'h4, 32'h8000_00F0, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.result !== 32'h0)   begin n_err++; $display("FAIL slt_neg_result: got %h want 0", bus.result); end
      n_cmp++; if (bus.overflow !== 1'b0)  begin n_err++; $display("FAIL slt_ovf_clear: got %b want 0", bus.overflow); end
      tick();
   endtask

   task automatic test_back_to_back();
      drive(4'b0000, 32'd2, 32'd3, 1'b0, 32'h0);
      tick();
      n_cmp++; if (bus.done !== 1'b1 || bus.result !== 32'd5) begin n_err++; $display("FAIL b2b_first: got done=%b result=%h want 1/5", bus.done, bus.result); end
      drive(4'b0001, 32'd10, 32'd4, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.done !== 1'b1)    begin n_err++; $display("FAIL b2b_second_done: got %b want 1", bus.done); end
      n_cmp++; if (bus.result !== 32'd6) begin n_err++; $display("FAIL b2b_second_result: got %h want 6", bus.result); end
      bus.readData1 = 32'h1234;
      tick();
      tick();
      n_cmp++; if (bus.done !== 1'b0)    begin n_err++; $display("FAIL hold_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.result !== 32'd6) begin n_err++; $display("FAIL hold_result: got %h want 6", bus.result); end
   endtask

`ifdef ALU_MULDIV_EN
   task automatic test_mulu();
      int n;
      int early_done;
      drive(4'b0000, 32'd2, 32'd3, 1'b0, 32'h0);
      tick();
      drive(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      bus.readData1 = 32'h0;
      bus.readData2 = 32'h0;
      n = 0;
      early_done = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         if (bus.done !== 1'b0 || bus.result !== 32'd5) early_done++;
         if (n == 5) drive(4'b0000, 32'd1, 32'd1, 1'b0, 32'h0);
         tick();
         bus.start = 1'b0;
         n++;
      end
      n_cmp++; if (n != 32)          begin n_err++; $display("FAIL mulu_busy_cycles: got %0d want 32", n); end
      n_cmp++; if (early_done != 0)  begin n_err++; $display("FAIL mulu_outputs_during_iter: got %0d bad cycles want 0", early_done); end
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL mulu_done: got %b want 1", bus.done); end
      n_cmp++; if (bus.resultHi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulu_hi: got %h want fffffffe", bus.resultHi); end
      n_cmp++; if (bus.result !== 32'h0000_0001)   begin n_err++; $display("FAIL mulu_lo: got %h want 00000001", bus.result); end
      tick();
      n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL mulu_after: got done=%b busy=%b want 0/0", bus.done, bus.busy); end
   endtask

   task automatic test_divu();
      int n;
      drive(4'b1101, 32'd100, 32'd7, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      n_cmp++; if (n != 32)               begin n_err++; $display("FAIL divu_busy_cycles: got %0d want 32", n); end
      n_cmp++; if (bus.done !== 1'b1)     begin n_err++; $display("FAIL divu_done: got %b want 1", bus.done); end
      n_cmp++; if (bus.result !== 32'd14) begin n_err++; $display("FAIL divu_quot: got %h want 0000000e", bus.result); end
      n_cmp++; if (bus.resultHi !== 32'd2) begin n_err++; $display("FAIL divu_rem: got %h want 2", bus.resultHi); end
      n_cmp++; if (bus.divByZero !== 1'b0) begin n_err++; $display("FAIL divu_dbz: got %b want 0", bus.divByZero); end
      tick();
      drive(4'b1101, 32'd100, 32'd0, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL div0_timing: got done=%b busy=%b want 1/0", bus.done, bus.busy); end
      n_cmp++; if (bus.result !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_result: got %h want ffffffff", bus.result); end
      n_cmp++; if (bus.resultHi !== 32'd100)     begin n_err++; $display("FAIL div0_hi: got %h want 64", bus.resultHi); end
      n_cmp++; if (bus.divByZero !== 1'b1)       begin n_err++; $display("FAIL div0_dbz: got %b want 1", bus.divByZero); end
      tick();
   endtask

   task automatic test_reset_abort();
      int seen_done;
      drive(4'b1100, 32'd3, 32'd3, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b want 1", bus.busy); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL abort_ctrl: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
      n_cmp++; if (bus.result !== 32'h0 || bus.resultHi !== 32'h0 || bus.zero !== 1'b1) begin n_err++; $display("FAIL abort_outputs: got %h/%h/%b want 0/0/1", bus.result, bus.resultHi, bus.zero); end
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
      end
      n_cmp++; if (seen_done != 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen_done); end
      drive(4'b0000, 32'd2, 32'd3, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.done !== 1'b1 || bus.result !== 32'd5) begin n_err++; $display("FAIL abort_then_add: got done=%b result=%h want 1/5", bus.done, bus.result); end
      tick();
   endtask
`else
   task automatic test_muldiv_disabled();
      drive(4'b0000, 32'd2, 32'd3, 1'b0, 32'h0);
      tick();
      drive(4'b1100, 32'd3, 32'd3, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.done !== 1'b1)       begin n_err++; $display("FAIL mul_off_done: got %b want 1", bus.done); end
      n_cmp++; if (bus.busy !== 1'b0)       begin n_err++; $display("FAIL mul_off_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.result !== 32'h0 || bus.resultHi !== 32'h0 || bus.zero !== 1'b1) begin n_err++; $display("FAIL mul_off_outputs: got %h/%h/%b want 0/0/1", bus.result, bus.resultHi, bus.zero); end
      tick();
      n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL mul_off_after: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
      drive(4'b1101, 32'd100, 32'd0, 1'b0, 32'h0);
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.result !== 32'h0 || bus.resultHi !== 32'h0 || bus.divByZero !== 1'b0) begin n_err++; $display("FAIL div_off_outputs: got %h/%h/%b want 0/0/0", bus.result, bus.resultHi, bus.divByZero); end
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL div_off_timing: got done=%b busy=%b want 1/0", bus.done, bus.busy); end
      tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      bus.start     = 1'b0;
      bus.ALUOp     = 4'b0000;
      bus.readData1 = 32'h0;
      bus.readData2 = 32'h0;
      bus.immediate = 32'h0;
      bus.ALUSrcB   = 1'b0;
      test_reset();
      test_add_overflow();
      test_sub_immediate();
      test_single_cycle_ops();
      test_back_to_back();
`ifdef ALU_MULDIV_EN
      test_mulu();
      test_divu();
      test_reset_abort();
`else
      test_muldiv_disabled();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/multi_cycle_alu.md
MULTI_CYCLE_ALU -- requirements
Module: multi_cycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8 to 64.
REQ-002 CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request to accept a new operation.
REQ-005 ALUOp  input  4  operation select, sampled with start.
REQ-006 readData1  input  WIDTH  operand A, sampled with start.
REQ-007 readData2  input  WIDTH  operand B (register path), sampled with start.
REQ-008 immediate  input  WIDTH  operand B (immediate path), sampled with start.
REQ-009 ALUSrcB  input  1  0 selects readData2 as B; 1 selects immediate.
REQ-010 busy  output  1  high while an iterative operation is in progress.
REQ-011 done  output  1  one-cycle pulse; result fields valid.
REQ-012 result  output  WIDTH  primary result: low half of product, or quotient.
REQ-013 resultHi  output  WIDTH  high half of product, or remainder; 0 for all other ops.
REQ-014 zero  output  1  high when result is 0.
REQ-015 overflow  output  1  signed overflow of ADD/SUB; 0 for all other ops.
REQ-016 divByZero  output  1  high when the completed DIVU had B equal to 0.

Function
REQ-017 FSM states: IDLE and ITER; start is accepted only in IDLE.
REQ-018 A and B are latched into internal registers when start is accepted; later input changes have no effect on the operation in progress.
REQ-019 Single-cycle ops, i.e. any ALUOp below 1100, accepted at edge k: result and flags are registered at edge k, done is high for the cycle after edge k, and the FSM stays in IDLE.
REQ-020 Op codes: 0000 A+B, 0001 A-B, 0010 B-A, 0011 A|B, 0100 A&B, 0101 ~A&B, 0110 A^B, 0111 A~^B.
REQ-021 Op codes: 1000 B<<A[log2 WIDTH-1:0], 1001 logical B>>shamt, 1010 arithmetic B>>>shamt, 1011 signed A<B gives 1, otherwise 0.
REQ-022 1100 MULU: unsigned shift-add, one bit per cycle; full 2*WIDTH product placed as {resultHi,result}.
REQ-023 1101 DIVU: unsigned restoring divide, one bit per cycle; quotient goes to result, remainder to resultHi.
REQ-024 Op codes 1110 and 1111 are reserved; they complete as single-cycle ops with result=0, resultHi=0 and zero=1.
REQ-025 Iterative op accepted at edge k: the FSM enters ITER and busy is high after edges k through k+WIDTH-1.
REQ-026 At edge k+WIDTH the iterative op returns to IDLE, busy drops, and done pulses for one cycle.
REQ-027 DIVU with B=0 skips iteration: it completes as a single-cycle op with result all ones, resultHi=A and divByZero=1.
REQ-028 start while busy is ignored, with no queuing and no effect on the op in progress.
REQ-029 start in the cycle done is high is accepted, giving back-to-back operation.
REQ-030 result, resultHi and the flags hold their values from done until the next accepted op completes; intermediate iteration values are never visible on result.
REQ-031 Adder arithmetic is modulo 2^WIDTH; overflow is set when the operand signs match as the op requires and the result sign differs.

Reset
REQ-032 When Reset is low at a rising edge: FSM goes to IDLE; busy, done, overflow and divByZero go to 0; result and resultHi go to 0; zero goes to 1.
REQ-033 Reset during ITER aborts the operation with no done pulse; the first start after Reset is released is accepted normally.

Configuration
REQ-034 Macro ALU_MULDIV_EN: when defined, MULU and DIVU are built as specified above.
REQ-035 When ALU_MULDIV_EN is undefined: no iterative hardware is built, the FSM never leaves IDLE, busy is tied to 0, and codes 1100 and 1101 behave as reserved codes (REQ-024).

Verification (WIDTH=32)
REQ-036 ADD with A=0x7FFFFFFF, B=1 -> result 0x80000000, overflow=1, done one cycle after start.
REQ-037 SUB with A=5, B via immediate 5 (ALUSrcB=1) -> result 0, zero=1, overflow=0.
REQ-038 MULU with A=0xFFFFFFFF, B=0xFFFFFFFF -> resultHi 0xFFFFFFFE, result 0x00000001; busy lasts 32 cycles; a second start issued mid-operation is ignored.
REQ-039 DIVU with A=100, B=7 -> result 14, resultHi 2; DIVU with B=0 -> result 0xFFFFFFFF, resultHi 100, divByZero=1.
REQ-040 Reset low at cycle 10 of a MULU -> busy=0, done stays 0, outputs at reset values; a following ADD with A=2, B=3 gives result 5.
REQ-041 Build without ALU_MULDIV_EN, ALUOp=1100 -> done one cycle after start, result 0, busy never asserted.
